ram_cmd_ctrl: RTL and testbench
===============================

Name: ram_cmd_ctrl

Overview:
Command front-end that sits directly upstream of the single-port RAM (8-bit data, 6-bit address, we, clk, q).
- Accepts read/write commands on a valid/ready interface.
- Drives the RAM's data/addr/we from registers.
- Waits out the RAM read latency and returns read data on a valid/ready response port.
- Provides a hardware init sweep that fills every location with a constant.

Parameters:
- DATA_W, 8, data width; matches RAM data port.
- ADDR_W, 6, address width; matches RAM address port.
- DEPTH, 64, number of RAM locations swept by init; equals 2**ADDR_W.
- RD_LAT, 1, cycles from the edge that samples ram_addr until ram_q is valid; allowed range 1..4.
- FILL_VALUE, 8'h00, value written to every location during the init sweep.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller accepts a command this cycle.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  target address.
- cmd_data  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer takes the response.
- rsp_data  output  DATA_W  read data.
- init_req  input  1  single-cycle request to start the fill sweep.
- init_busy  output  1  sweep in progress.
- ram_data  output  DATA_W  to RAM data.
- ram_addr  output  ADDR_W  to RAM addr.
- ram_we  output  1  to RAM we.
- ram_q  input  DATA_W  from RAM q.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - ram_we=0, ram_addr=0, ram_data=0.
  - rsp_valid=0, rsp_data=0.
  - init_busy=0.
  - cmd_ready=0 while rst is high.
  - Reset mid-operation aborts everything: a partial init sweep leaves RAM contents undefined, and a pending response is dropped.
- States and transitions:
  - IDLE: cmd_ready=1.
    - init_req=1 → INIT. Init wins over a simultaneous cmd_valid; that command is not accepted.
    - Otherwise cmd_valid & cmd_we → WR.
    - Otherwise cmd_valid & !cmd_we → RD_WAIT.
    - On acceptance, cmd_addr and cmd_data are registered onto ram_addr and ram_data.
  - WR: ram_we=1 for exactly this one cycle; cmd_ready=0. → IDLE. Writes produce no response.
  - RD_WAIT: ram_we=0. A latency counter counts RD_LAT cycles, then ram_q is captured into rsp_data and the state → RSP.
  - RSP: rsp_valid=1 and rsp_data is held stable. Leave on rsp_valid & rsp_ready → IDLE; rsp_valid drops the following cycle.
  - INIT: init_busy=1, ram_we=1, ram_data=FILL_VALUE. ram_addr steps 0,1,…,DEPTH-1, one per cycle. After the write to DEPTH-1 → IDLE (ram_we=0, init_busy=0). The sweep takes exactly DEPTH cycles with we high.
- Command rules:
  - cmd_ready is low in every state except IDLE, so commands are strictly serialised.
  - init_req outside IDLE is ignored, not queued.
- Command throughput:
  - Write: one per 2 cycles.
  - Read: accept-to-rsp_valid = RD_LAT+1 cycles, plus any backpressure.
- Address arithmetic: ADDR_W unsigned. The init counter is ADDR_W+1 bits so termination is detected without wrap. No other wrap-around is possible, because commands carry an absolute address.
- Outputs are registered; there is no combinational path from inputs to ram_* outputs.

Optional Feature:
- Macro: RAM_CMD_CTRL_STATS_EN.
- Defined:
  - Adds output wr_count[15:0], incremented per WR cycle; init writes are not counted.
  - Adds output rd_count[15:0], incremented per RSP handshake.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ram_ctrl_pkg:
  - state enum (IDLE, WR, RD_WAIT, RSP, INIT).
  - default DATA_W/ADDR_W/DEPTH constants.
  - RD_LAT maximum.
- Natural sub-module ram_init_sweeper: address counter plus done flag, instantiated by ram_cmd_ctrl.

Test Plan:
- Writes 0x01@0, 0x02@1, 0x03@2, then reads 0, 1, 2 with rsp_ready=1 → rsp_data 0x01, 0x02, 0x03, each RD_LAT+1 cycles after acceptance; ram_we high exactly 1 cycle per write.
- Read addr 1 with rsp_ready=0 for 5 cycles → rsp_valid held, rsp_data stable at 0x02, cmd_ready=0 until the handshake.
- init_req with FILL_VALUE=8'hA5 → 64 consecutive cycles of ram_we=1, addresses 0..63; then reading addr 4 → 0xA5.
- init_req and cmd_valid (write 0x04@1) in the same IDLE cycle → INIT starts, command not accepted; the command is accepted after init_busy falls.
- rst asserted mid-INIT at address 20 → ram_we=0, init_busy=0, state IDLE immediately (async); cmd_ready=1 after release.
- STATS_EN build: 3 writes, 2 reads → wr_count=3, rd_count=2; 16'hFFFF saturation is checked by forcing the counter.

Source files
------------

// File: rtl/ram_cmd_ctrl_pkg.sv
// Shared types and default constants for the RAM command controller.
// Optional statistics counters are enabled with RAM_CMD_CTRL_STATS_EN.
package ram_ctrl_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_WAIT = 3'd2,
        RSP     = 3'd3,
        INIT    = 3'd4
    } state_t;

    // Defaults match the attached single-port RAM.
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DEPTH  = 64;

    // Deepest RAM read pipeline the latency counter is sized for.
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_W      = $clog2(RD_LAT_MAX + 1);

    // Saturating increment used by the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ram_cmd_ctrl_if.sv
// Bus bundle between the command source / RAM and the controller.
// The slave modport is the controller's view; master is the surrounding logic.
// Statistics signals exist only when RAM_CMD_CTRL_STATS_EN is defined.
interface ram_cmd_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    logic              init_req;
    logic              init_busy;

    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

`ifdef RAM_CMD_CTRL_STATS_EN
    logic [15:0]       wr_count;
    logic [15:0]       rd_count;
`endif

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        input  init_req,
        output init_busy,
        output ram_data, ram_addr, ram_we,
        input  ram_q
`ifdef RAM_CMD_CTRL_STATS_EN
        ,
        output wr_count, rd_count
`endif
    );

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        output init_req,
        input  init_busy,
        input  ram_data, ram_addr, ram_we,
        output ram_q
`ifdef RAM_CMD_CTRL_STATS_EN
        ,
        input  wr_count, rd_count
`endif
    );

endinterface

// File: rtl/ram_cmd_ctrl_init_sweeper.sv
// Address generator for the fill sweep: counts 0..DEPTH-1 and flags the
// last location. The counter is one bit wider than the address so the
// terminal count never aliases back to zero.
module ram_init_sweeper #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_active,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    logic [CNT_W-1:0] r_cnt;

    // Restart at zero on a new sweep, otherwise advance once per sweep cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
        end else if (i_active) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_addr = r_cnt[ADDR_W-1:0];
    assign o_last = (r_cnt == CNT_LAST);

endmodule

// File: rtl/ram_cmd_ctrl.sv
// Command front-end for a single-port RAM: serialises read/write commands,
// waits out the RAM read latency, returns read data on a response port and
// can sweep a constant into every location.
// Define RAM_CMD_CTRL_STATS_EN to add saturating write/read counters.
module ram_cmd_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                DEPTH      = DEF_DEPTH,
    parameter int                RD_LAT     = 1,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
    input logic          clk,
    input logic          rst,
    ram_cmd_ctrl_if.slave bus
);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_init_start;
    logic              w_lat_done;
    logic              w_sweep_last;
    logic [ADDR_W-1:0] w_sweep_addr;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [DATA_W-1:0] r_rsp_data;

    ram_init_sweeper #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sweeper (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_init_start),
        .i_active (r_state == INIT),
        .o_addr   (w_sweep_addr),
        .o_last   (w_sweep_last)
    );

    assign w_lat_done = (r_lat_cnt == LAT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an init request beats a simultaneous command.
    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_init_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.init_req) begin
                    w_next       = INIT;
                    w_init_start = 1'b1;
                end else if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = bus.cmd_we ? WR : RD_WAIT;
                end
            end
            WR:      w_next = IDLE;
            RD_WAIT: if (w_lat_done) w_next = RSP;
            RSP:     if (bus.rsp_ready) w_next = IDLE;
            INIT:    if (w_sweep_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // RAM drive registers, read-latency counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_lat_cnt  <= '0;
            r_rsp_data <= '0;
        end else begin
            r_we <= (w_next == WR) || (w_next == INIT);
            if (w_accept) begin
                r_addr <= bus.cmd_addr;
                r_data <= bus.cmd_data;
            end else if (w_init_start) begin
                r_data <= FILL_VALUE;
            end
            if (r_state == RD_WAIT) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end else begin
                r_lat_cnt <= '0;
            end
            if ((r_state == RD_WAIT) && w_lat_done) begin
                r_rsp_data <= bus.ram_q;
            end
        end
    end

    assign bus.ram_addr  = (r_state == INIT) ? w_sweep_addr : r_addr;
    assign bus.ram_data  = r_data;
    assign bus.ram_we    = r_we;
    assign bus.cmd_ready = (r_state == IDLE) && !rst;
    assign bus.rsp_valid = (r_state == RSP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.init_busy = (r_state == INIT);

`ifdef RAM_CMD_CTRL_STATS_EN
    logic [15:0] r_wr_count;
    logic [15:0] r_rd_count;

    // Saturating counters: one per write cycle, one per response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            if (r_state == WR) begin
                r_wr_count <= sat_inc16(r_wr_count);
            end
            if ((r_state == RSP) && bus.rsp_ready) begin
                r_rd_count <= sat_inc16(r_rd_count);
            end
        end
    end

    assign bus.wr_count = r_wr_count;
    assign bus.rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Directed bench for ram_cmd_ctrl with a behavioural single-port RAM
// (one-cycle registered read). Statistics checks compile only when
// RAM_CMD_CTRL_STATS_EN is defined.
module tb_ram_cmd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nChecks = 0;
    int   nErrors = 0;
    int   n;
    int   c;
    int   bad;

    logic [7:0] mem [64];
    logic [7:0] ramQ;

    ram_cmd_ctrl_if #(.DATA_W(8), .ADDR_W(6)) bus ();

    ram_cmd_ctrl #(
        .DATA_W     (8),
        .ADDR_W     (6),
        .DEPTH      (64),
        .RD_LAT     (1),
        .FILL_VALUE (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write-enable store, registered read.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
        ramQ <= mem[bus.ram_addr];
    end
    assign bus.ram_q = ramQ;

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic we,
                                 input logic [5:0] a, input logic [7:0] d);
        bus.cmd_valid = v;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
    endtask

    task automatic doWrite(input logic [5:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
        tick;
        applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
        checkOutput("wr_we_high", 32'(bus.ram_we), 1);
        checkOutput("wr_addr", 32'(bus.ram_addr), 32'(a));
        checkOutput("wr_data", 32'(bus.ram_data), 32'(d));
        checkOutput("wr_busy_ready", 32'(bus.cmd_ready), 0);
        tick;
        checkOutput("wr_we_low", 32'(bus.ram_we), 0);
        checkOutput("wr_done_ready", 32'(bus.cmd_ready), 1);
    endtask

    task automatic doRead(input logic [5:0] a, input logic [7:0] exp, input int hold);
        applyStimulus(1'b1, 1'b0, a, 8'd0);
        bus.rsp_ready = (hold == 0);
        tick;
        applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
        checkOutput("rd_wait_valid", 32'(bus.rsp_valid), 0);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick;
            n++;
        end
        checkOutput("rd_latency", 32'(n), 2);
        checkOutput("rd_data", 32'(bus.rsp_data), 32'(exp));
        checkOutput("rd_cmd_ready", 32'(bus.cmd_ready), 0);
        for (int i = 0; i < hold; i++) begin
            tick;
            checkOutput("bp_valid", 32'(bus.rsp_valid), 1);
            checkOutput("bp_data", 32'(bus.rsp_data), 32'(exp));
            checkOutput("bp_cmd_ready", 32'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_drop", 32'(bus.rsp_valid), 0);
        checkOutput("rsp_idle_ready", 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
        bus.rsp_ready = 1'b0;
        bus.init_req  = 1'b0;

        // Reset values while rst is held.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        checkOutput("rst_ram_we", 32'(bus.ram_we), 0);
        checkOutput("rst_ram_addr", 32'(bus.ram_addr), 0);
        checkOutput("rst_ram_data", 32'(bus.ram_data), 0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("rst_rsp_data", 32'(bus.rsp_data), 0);
        checkOutput("rst_init_busy", 32'(bus.init_busy), 0);
        rst = 1'b0;
        #1;
        checkOutput("rel_cmd_ready", 32'(bus.cmd_ready), 1);

        // Basic writes then reads.
        doWrite(6'd0, 8'h01);
        doWrite(6'd1, 8'h02);
        doWrite(6'd2, 8'h03);
        doRead(6'd0, 8'h01, 0);
        doRead(6'd1, 8'h02, 0);
        doRead(6'd2, 8'h03, 0);

        // Backpressure: response held for 5 cycles.
        doRead(6'd1, 8'h02, 5);

        // Top address boundary.
        doWrite(6'd63, 8'h3C);
        doRead(6'd63, 8'h3C, 0);

        // Full fill sweep.
        bus.init_req = 1'b1;
        tick;
        bus.init_req = 1'b0;
        c   = 0;
        bad = 0;
        while (bus.init_busy && c < 200) begin
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== c[5:0] || bus.ram_data !== 8'hA5) bad++;
            c++;
            tick;
        end
        checkOutput("init_cycles", 32'(c), 64);
        checkOutput("init_seq_bad", 32'(bad), 0);
        checkOutput("init_end_we", 32'(bus.ram_we), 0);
        checkOutput("init_end_ready", 32'(bus.cmd_ready), 1);
        doRead(6'd4, 8'hA5, 0);
        doRead(6'd63, 8'hA5, 0);

        // Init beats a simultaneous command; command waits for the sweep.
        bus.init_req = 1'b1;
        applyStimulus(1'b1, 1'b1, 6'd1, 8'h04);
        tick;
        bus.init_req = 1'b0;
        checkOutput("arb_busy", 32'(bus.init_busy), 1);
        checkOutput("arb_addr", 32'(bus.ram_addr), 0);
        checkOutput("arb_data", 32'(bus.ram_data), 'hA5);
        checkOutput("arb_ready", 32'(bus.cmd_ready), 0);
        c = 0;
        while (bus.init_busy && c < 200) begin
            c++;
            tick;
        end
        checkOutput("arb_init_cycles", 32'(c), 64);
        checkOutput("arb_after_ready", 32'(bus.cmd_ready), 1);
        tick;
        applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
        checkOutput("arb_wr_we", 32'(bus.ram_we), 1);
        checkOutput("arb_wr_addr", 32'(bus.ram_addr), 1);
        checkOutput("arb_wr_data", 32'(bus.ram_data), 'h04);
        tick;
        doRead(6'd1, 8'h04, 0);

        // Asynchronous reset in the middle of a sweep.
        bus.init_req = 1'b1;
        tick;
        bus.init_req = 1'b0;
        c = 0;
        while (bus.ram_addr != 6'd20 && c < 100) begin
            tick;
            c++;
        end
        checkOutput("mid_addr", 32'(bus.ram_addr), 20);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_we", 32'(bus.ram_we), 0);
        checkOutput("mid_rst_busy", 32'(bus.init_busy), 0);
        checkOutput("mid_rst_ready", 32'(bus.cmd_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_rel_ready", 32'(bus.cmd_ready), 1);
        checkOutput("mid_rel_busy", 32'(bus.init_busy), 0);

        // Traffic after reset (also feeds the statistics counters).
        doWrite(6'd5, 8'h77);
        doWrite(6'd6, 8'h88);
        doWrite(6'd7, 8'h99);
        doRead(6'd5, 8'h77, 0);
        doRead(6'd6, 8'h88, 0);
`ifdef RAM_CMD_CTRL_STATS_EN
        checkOutput("stat_wr", 32'(bus.wr_count), 3);
        checkOutput("stat_rd", 32'(bus.rd_count), 2);
        force dut.r_wr_count = 16'hFFFF;
        tick;
        release dut.r_wr_count;
        doWrite(6'd8, 8'h11);
        checkOutput("stat_wr_sat", 32'(bus.wr_count), 'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
